// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - circular store buffer between core and data_ram with load forwarding
// Stores queue in push order and drain one per cycle whenever the RAM write port is free.
module store_buffer #(
    parameter int n     = 10,
    parameter int m     = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       memwr,
    input  logic [n-1:0]               addr,
    input  logic [m-1:0]               write_data,
    output logic [m-1:0]               read_data,
    output logic                       stall,
    input  logic                       ram_busy,
    output logic                       ram_we,
    output logic [n-1:0]               ram_addr,
    output logic [m-1:0]               ram_wdata,
    input  logic [m-1:0]               ram_rdata,
    output logic [$clog2(DEPTH):0]     fill_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [n-1:0]  r_addr [DEPTH];
    logic [m-1:0]  r_data [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_empty;
    logic          w_full;
    logic          w_drain;
    logic          w_push;
    logic          w_fwd_hit;
    logic [m-1:0]  w_fwd_data;
    logic [AW-1:0] w_idx;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_drain = !w_empty && !ram_busy;
    // A full buffer only refuses a store when the head cannot leave this cycle.
    assign stall   = memwr && w_full && ram_busy;
    assign w_push  = memwr && !stall;

    assign ram_we     = w_drain;
    assign ram_addr   = w_empty ? '0 : r_addr[r_head];
    assign ram_wdata  = w_empty ? '0 : r_data[r_head];
    assign fill_level = r_count;

    // Walk entries oldest to youngest so the last match wins; the head counts even while draining.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        w_idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + AW'(i);
            if ((CW'(i) < r_count) && (r_addr[w_idx] == addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_data[w_idx];
            end
        end
        read_data = w_fwd_hit ? w_fwd_data : ram_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_addr[r_tail] <= addr;
                r_data[r_tail] <= write_data;
                r_tail         <= r_tail + AW'(1);
            end
            if (w_drain) begin
                r_head <= r_head + AW'(1);
            end
            case ({w_push, w_drain})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed self-checking bench for store_buffer
// A behavioural data_ram holds addr-derived stale contents so forwarding is distinguishable.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        memwr;
    logic [9:0]  addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        stall;
    logic        ram_busy;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [2:0]  fill_level;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] ram [0:1023];
    bit          mon_en = 1'b0;
    logic [9:0]  mon_a [$];
    logic [31:0] mon_d [$];

    store_buffer #(.n(10), .m(32), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .memwr      (memwr),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data),
        .stall      (stall),
        .ram_busy   (ram_busy),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .fill_level (fill_level)
    );

    always #5 clk = ~clk;

    assign ram_rdata = ram[addr];

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 32'hA000_0000 + i;
        forever begin
            @(posedge clk);
            if (ram_we) ram[ram_addr] = ram_wdata;
        end
    end

    always @(negedge clk) begin
        if (mon_en && ram_we) begin
            mon_a.push_back(ram_addr);
            mon_d.push_back(ram_wdata);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; memwr = 1'b1; addr = 10'd5; write_data = 32'h55; ram_busy = 1'b0;
        #2;
        vectors++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
        vectors++; if (ram_addr !== 10'd0) begin errors++; $display("FAIL reset_ram_addr: got %0d want 0", ram_addr); end
        vectors++; if (ram_wdata !== 32'd0) begin errors++; $display("FAIL reset_ram_wdata: got %h want 0", ram_wdata); end
        vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        vectors++; if (fill_level !== 3'd0) begin errors++; $display("FAIL reset_fill: got %0d want 0", fill_level); end
        vectors++; if (read_data !== 32'hA000_0005) begin errors++; $display("FAIL reset_read_data: got %h want a0000005", read_data); end
        tick; tick;
        memwr = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_forwarding;
        ram_busy = 1'b1;
        memwr = 1'b1; addr = 10'd96; write_data = 32'd2;
        tick;
        write_data = 32'd7;
        #1;
        vectors++; if (read_data !== 32'd2) begin errors++; $display("FAIL fwd_same_cycle: got %h want 2", read_data); end
        tick;
        memwr = 1'b0;
        #1;
        vectors++; if (fill_level !== 3'd2) begin errors++; $display("FAIL fwd_fill: got %0d want 2", fill_level); end
        vectors++; if (read_data !== 32'd7) begin errors++; $display("FAIL fwd_youngest: got %h want 7", read_data); end
        addr = 10'd92;
        #1;
        vectors++; if (read_data !== 32'hA000_005C) begin errors++; $display("FAIL fwd_miss: got %h want a000005c", read_data); end
        addr = 10'd96; ram_busy = 1'b0;
        #1;
        vectors++; if (ram_we !== 1'b1 || ram_wdata !== 32'd2) begin errors++; $display("FAIL fwd_drain1: got we=%b data=%h want we=1 data=2", ram_we, ram_wdata); end
        tick;
        #1;
        vectors++; if (ram_wdata !== 32'd7) begin errors++; $display("FAIL fwd_drain2: got %h want 7", ram_wdata); end
        vectors++; if (read_data !== 32'd7) begin errors++; $display("FAIL fwd_draining_entry: got %h want 7", read_data); end
        tick;
        #1;
        vectors++; if (fill_level !== 3'd0 || read_data !== 32'd7) begin errors++; $display("FAIL fwd_ram_final: got fill=%0d data=%h want fill=0 data=7", fill_level, read_data); end
    endtask

    task automatic test_single_store;
        ram_busy = 1'b0; memwr = 1'b1; addr = 10'd96; write_data = 32'd2;
        #1;
        vectors++; if (stall !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("FAIL single_accept: got stall=%b we=%b want 0 0", stall, ram_we); end
        tick;
        memwr = 1'b0;
        #1;
        vectors++; if (ram_we !== 1'b1 || ram_addr !== 10'd96 || ram_wdata !== 32'd2 || fill_level !== 3'd1) begin
            errors++; $display("FAIL single_drain: got we=%b a=%0d d=%h fill=%0d want 1 96 2 1", ram_we, ram_addr, ram_wdata, fill_level);
        end
        tick;
        #1;
        vectors++; if (ram_we !== 1'b0 || fill_level !== 3'd0) begin errors++; $display("FAIL single_done: got we=%b fill=%0d want 0 0", ram_we, fill_level); end
        vectors++; if (read_data !== 32'd2) begin errors++; $display("FAIL single_ram: got %h want 2", read_data); end
    endtask

    task automatic test_full_stall;
        int n;
        ram_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            memwr = 1'b1; addr = 10'(4 * i); write_data = 32'(10 + i);
            tick;
        end
        addr = 10'd16; write_data = 32'd14;
        #1;
        vectors++; if (fill_level !== 3'd4 || stall !== 1'b1) begin errors++; $display("FAIL full_stall: got fill=%0d stall=%b want 4 1", fill_level, stall); end
        tick;
        #1;
        vectors++; if (fill_level !== 3'd4 || stall !== 1'b1) begin errors++; $display("FAIL full_hold: got fill=%0d stall=%b want 4 1", fill_level, stall); end
        mon_a.delete(); mon_d.delete(); mon_en = 1'b1;
        ram_busy = 1'b0;
        #1;
        vectors++; if (stall !== 1'b0 || ram_we !== 1'b1 || ram_addr !== 10'd0) begin errors++; $display("FAIL full_release: got stall=%b we=%b a=%0d want 0 1 0", stall, ram_we, ram_addr); end
        tick;
        memwr = 1'b0;
        #1;
        vectors++; if (fill_level !== 3'd4) begin errors++; $display("FAIL full_swap: got fill=%0d want 4", fill_level); end
        n = 0;
        while (fill_level !== 3'd0 && n < 20) begin tick; n++; end
        vectors++; if (n >= 20) begin errors++; $display("FAIL full_drain_timeout: fill=%0d want 0", fill_level); end
        mon_en = 1'b0;
        vectors++; if (mon_d.size() != 5) begin errors++; $display("FAIL full_count: got %0d drains want 5", mon_d.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                vectors++; if (mon_a[i] !== 10'(4 * i) || mon_d[i] !== 32'(10 + i)) begin
                    errors++; $display("FAIL full_order[%0d]: got %0d/%h want %0d/%h", i, mon_a[i], mon_d[i], 4 * i, 10 + i);
                end
            end
        end
    endtask

    task automatic test_order_wrap;
        logic [15:0] pat;
        int idx, c;
        bit acc;
        pat = 16'b0000_1101_0011_1011;
        idx = 0; c = 0;
        mon_a.delete(); mon_d.delete(); mon_en = 1'b1;
        while ((idx < 6 || fill_level !== 3'd0) && c < 40) begin
            ram_busy = pat[c % 16];
            memwr = (idx < 6);
            addr = 10'(200 + 4 * idx);
            write_data = 32'(idx + 1);
            #1;
            acc = memwr && !stall;
            tick;
            if (acc) idx++;
            c++;
        end
        memwr = 1'b0; ram_busy = 1'b0;
        mon_en = 1'b0;
        vectors++; if (c >= 40) begin errors++; $display("FAIL order_timeout: idx=%0d fill=%0d", idx, fill_level); end
        vectors++; if (mon_d.size() != 6) begin errors++; $display("FAIL order_count: got %0d drains want 6", mon_d.size()); end
        else begin
            for (int i = 0; i < 6; i++) begin
                vectors++; if (mon_d[i] !== 32'(i + 1)) begin errors++; $display("FAIL order[%0d]: got %h want %h", i, mon_d[i], i + 1); end
            end
        end
    endtask

    task automatic test_reset_mid;
        ram_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            memwr = 1'b1; addr = 10'(300 + 4 * i); write_data = 32'(32'h30 + i);
            tick;
        end
        memwr = 1'b0;
        #1;
        vectors++; if (fill_level !== 3'd3) begin errors++; $display("FAIL rmid_fill: got %0d want 3", fill_level); end
        ram_busy = 1'b0;
        #1;
        vectors++; if (ram_we !== 1'b1) begin errors++; $display("FAIL rmid_pre_we: got %b want 1", ram_we); end
        #1;
        rst = 1'b1;
        #1;
        vectors++; if (ram_we !== 1'b0 || fill_level !== 3'd0 || ram_addr !== 10'd0) begin
            errors++; $display("FAIL rmid_async: got we=%b fill=%0d a=%0d want 0 0 0", ram_we, fill_level, ram_addr);
        end
        tick; tick;
        rst = 1'b0;
        mon_a.delete(); mon_d.delete(); mon_en = 1'b1;
        repeat (5) tick;
        mon_en = 1'b0;
        vectors++; if (mon_d.size() != 0 || fill_level !== 3'd0) begin errors++; $display("FAIL rmid_no_drain: got %0d drains fill=%0d want 0 0", mon_d.size(), fill_level); end
    endtask

    task automatic test_program;
        ram_busy = 1'b0;
        mon_a.delete(); mon_d.delete(); mon_en = 1'b1;
        memwr = 1'b1; addr = 10'd96; write_data = 32'd2;
        tick;
        addr = 10'd92; write_data = 32'd4;
        tick;
        memwr = 1'b0; addr = 10'd0;
        tick; tick;
        mon_en = 1'b0;
        vectors++; if (mon_d.size() != 2) begin errors++; $display("FAIL prog_count: got %0d writes want 2", mon_d.size()); end
        else begin
            vectors++; if (mon_a[0] !== 10'd96 || mon_d[0] !== 32'd2) begin errors++; $display("FAIL prog_first: got %0d/%h want 96/2", mon_a[0], mon_d[0]); end
            vectors++; if (mon_a[1] !== 10'd92 || mon_d[1] !== 32'd4) begin errors++; $display("FAIL prog_second: got %0d/%h want 92/4", mon_a[1], mon_d[1]); end
        end
        addr = 10'd96;
        #1;
        vectors++; if (read_data !== 32'd2) begin errors++; $display("FAIL prog_lw: got %h want 2", read_data); end
    endtask

    initial begin
        test_reset;
        test_forwarding;
        test_single_store;
        test_full_stall;
        test_order_wrap;
        test_reset_mid;
        test_program;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter n, default 10: address width in bits.
REQ-002 Parameter m, default 32: data width in bits.
REQ-003 Parameter DEPTH, default 4: number of buffer entries; a power of two, at least 2.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 memwr  input  1  core store request, sampled on the rising edge.
REQ-007 addr  input  n  core load/store address.
REQ-008 write_data  input  m  core store data.
REQ-009 read_data  output  m  load data returned to the core (combinational).
REQ-010 stall  output  1  store not accepted this cycle; the core holds memwr, addr and write_data.
REQ-011 ram_busy  input  1  RAM write port unavailable this cycle.
REQ-012 ram_we  output  1  drain write enable to data_ram.
REQ-013 ram_addr  output  n  drain address to data_ram.
REQ-014 ram_wdata  output  m  drain data to data_ram.
REQ-015 ram_rdata  input  m  data_ram combinational read data for addr.
REQ-016 fill_level  output  clog2(DEPTH)+1  number of valid entries.

Function
REQ-017 The buffer SHALL be a circular FIFO of DEPTH {addr, data} entries with head and tail pointers that wrap modulo DEPTH, plus a count register.
REQ-018 Drain condition: the buffer SHALL drain when count>0 and ram_busy=0.
REQ-019 Drain outputs: ram_we SHALL equal the drain condition, and ram_addr/ram_wdata SHALL equal the head entry.
REQ-020 Empty buffer: ram_addr and ram_wdata SHALL be 0 when count=0.
REQ-021 On a drain, head SHALL advance by one at the rising edge.
REQ-022 Push: when memwr=1 and stall=0, {addr, write_data} SHALL be written at tail, and tail SHALL advance at the edge.
REQ-023 Stall rule: stall SHALL equal memwr AND (count==DEPTH) AND ram_busy.
REQ-024 Full buffer with a simultaneous drain: the push SHALL be accepted with stall=0, since the drain frees a slot in the same cycle.
REQ-025 Simultaneous push and drain: count SHALL stay unchanged.
REQ-026 Push only: count SHALL increase by 1.
REQ-027 Drain only: count SHALL decrease by 1.
REQ-028 count SHALL never exceed DEPTH and SHALL never underflow.
REQ-029 Entries SHALL drain strictly in push order; no coalescing and no reordering.
REQ-030 Load forwarding: read_data SHALL be the data of the youngest valid entry whose addr equals the input addr; if there is no match, read_data SHALL be ram_rdata.
REQ-031 The entry being drained in the current cycle SHALL still count as valid for forwarding.
REQ-032 A store presented in the current cycle SHALL NOT be forwarded to a load in the same cycle.
REQ-033 fill_level SHALL equal count.
REQ-034 Latency: an accepted store SHALL reach the RAM no earlier than the cycle after acceptance, and exactly one cycle after acceptance if the buffer was empty and ram_busy=0.

Reset
REQ-035 While rst=1, head, tail and count SHALL be 0, and entry contents SHALL be cleared to 0.
REQ-036 While rst=1, outputs SHALL be: ram_we=0, ram_addr=0, ram_wdata=0, stall=0, fill_level=0, read_data=ram_rdata.
REQ-037 Reset asserted during a partial or full buffer SHALL discard all pending stores, and no ram_we pulse SHALL follow.

Verification
REQ-038 Single store: ram_busy=0; store addr=96, data=2 -> next cycle ram_we=1, ram_addr=96, ram_wdata=2, fill_level=1; the following cycle fill_level=0 and ram_we=0.
REQ-039 Forwarding: ram_busy=1; store 96/2, then store 96/7; load addr 96 -> read_data=7 while ram_rdata is stale. Load addr 92 -> read_data=ram_rdata.
REQ-040 Full/stall: ram_busy=1; 4 stores to addr 0,4,8,12 -> fill_level=4. Fifth store to 16 -> stall=1 and fill_level stays 4. Release ram_busy -> fifth store accepted that cycle with stall=0, fill_level stays 4, ram_addr=0.
REQ-041 Order and wrap: 6 stores with data 1..6 under intermittent ram_busy -> ram_wdata sequence on ram_we pulses is exactly 1,2,3,4,5,6, with pointers wrapping past DEPTH-1.
REQ-042 Reset mid-operation: fill_level=3, assert rst asynchronously between edges -> ram_we=0 and fill_level=0 immediately; no drains after release.
REQ-043 Program-level: sw 2 to addr 96 followed by sw 4 to addr 92 through the buffer into data_ram -> RAM writes occur in order 96/2 then 92/4, and a later lw from 96 returns 2.
